ui_redraw_scheduler: RTL
========================

Name: ui_redraw_scheduler

Overview:
Sequences LCD redraw jobs for the on-screen menu driven by the push-button cursor/period datapath.
- Watches cursor index and active-period count.
- Records which menu cells and the waveform area are stale in a pending bitmap.
- Issues one draw job at a time to the TFT draw engine over a req/ack handshake, with ack timeout and retry.
- Sits between the button adapter outputs and the LCD drawing engine.

Parameters:
NUM_CELLS, 11, number of menu cells (cursor indices 0..NUM_CELLS-1); max 15.
ACK_TIMEOUT, 4096, cycles to wait for iDraw_Ack before abandoning a job.
WAVE_REGION, 15, region code reported for the waveform redraw job.

Ports:
clk  input  1  system clock.
rst  input  1  asynchronous, active-high reset.
en  input  1  scheduler enable (menu screen active).
iCursor_Index  input  4  current cursor index from the button adapter.
iActive_Periods_Num  input  3  current SIN period count (0..4 = 1..5 periods).
oDraw_Req  output  1  draw job request; held until acked or timed out.
oDraw_Region  output  4  cell index 0..NUM_CELLS-1, or WAVE_REGION.
oDraw_Highlight  output  1  1 = draw cell in cursor colour; 0 for normal cells and wave jobs.
oDraw_Periods  output  3  period count to render; valid on wave jobs, else 0.
iDraw_Ack  input  1  one-cycle completion pulse from the draw engine.
oBusy  output  1  1 when any job is pending or in flight.
oTimeout_Err  output  1  sticky; set on any ack timeout.

Behaviour:
- Fixed decisions: one clock clk; reset rst is asynchronous and active-high.
- Reset values: all outputs 0, pending bitmap 0, prev_cursor 0, prev_periods 0, en_d 0, state IDLE, timeout counter 0.
- State registers: cell_pend[NUM_CELLS-1:0], wave_pend, prev_cursor, prev_periods, en_d.
- Capture and update rules, evaluated at every edge:
  - en rising (en=1, en_d=0): set all cell_pend bits and wave_pend (full refresh); load prev_* with current inputs.
  - en=1, iCursor_Index != prev_cursor: set cell_pend[prev_cursor] and cell_pend[iCursor_Index]. Any index >= NUM_CELLS is ignored and sets no bit. Update prev_cursor.
  - en=1, iActive_Periods_Num != prev_periods: set wave_pend; update prev_periods.
  - en=0: clear the pending bitmap; no new captures.
  - If a pending bit is set and cleared on the same edge, set wins.
- FSM:
  - IDLE:
    - If en=1 and any pending bit is set, pick the job: lowest-index set cell bit first, wave only when no cell bit is set.
    - Clear the chosen bit, drive the outputs, assert oDraw_Req, and go to WAIT.
    - Highlight is decided at issue time: oDraw_Highlight = (region == iCursor_Index).
  - WAIT:
    - oDraw_Req and all job outputs are held stable; the counter increments each cycle.
    - iDraw_Ack=1: deassert req, zero job outputs, counter to 0, return to IDLE.
    - Counter reaches ACK_TIMEOUT-1 without ack: deassert req, set oTimeout_Err, re-set the job's pending bit (retry), return to IDLE.
    - iDraw_Ack is ignored when oDraw_Req=0.
- Latency:
  - An input change before edge E0 sets pending at E0; oDraw_Req is high after E1.
  - There is at least one IDLE cycle between consecutive jobs.
- en falling during WAIT: the handshake completes (ack or timeout); no retry bit is set because pending is cleared while en=0.
- oBusy = (state==WAIT) | (|cell_pend) | wave_pend.
- oTimeout_Err clears only on rst.
- Counter width is clog2(ACK_TIMEOUT)+1; no wrap, because it saturates into the timeout.

Test Plan:
1. rst released with en=1, engine acks 2 cycles after each req -> jobs issue for regions 0..10 then 15; only region 0 (cursor=0) has Highlight=1; wave job has Periods=0; oBusy falls after the last ack.
2. Idle, cursor changes 3->4 -> exactly two jobs: region 3 with Highlight=0, then region 4 with Highlight=1; req high 2 cycles after the change.
3. Periods changes 0->2 while a cell job is in WAIT -> the cell job completes first, then region 15 issues with Periods=2.
4. Engine never acks, ACK_TIMEOUT=16 -> req drops after 16 cycles, oTimeout_Err=1, the same region re-requested; later ack retires it and oTimeout_Err stays 1.
5. Cursor toggles 5->6->5 before the first job is issued -> cells 5 and 6 each drawn once; final highlight on 5 only.
6. en dropped mid-WAIT, then ack -> req drops, no further jobs, oBusy=0; en raised again -> full refresh sequence restarts.

Source files
------------

// File: rtl/ui_redraw_scheduler.sv
// ui_redraw_scheduler
//
// Schedules LCD redraw jobs for the on-screen menu. It watches the cursor index
// and the active-period count, and it keeps a bitmap of stale menu cells plus one
// bit for the waveform area. Jobs go to the TFT draw engine one at a time over a
// req/ack handshake. A job that is not acked within ACK_TIMEOUT cycles is retried.
//
// Ports:
//   clk                  system clock
//   rst                  asynchronous active-high reset
//   en                   scheduler enable (menu screen active)
//   iCursor_Index        current cursor index from the button adapter
//   iActive_Periods_Num  current SIN period count (0..4 = 1..5 periods)
//   oDraw_Req            draw job request, held until acked or timed out
//   oDraw_Region         cell index 0..NUM_CELLS-1, or WAVE_REGION for the wave job
//   oDraw_Highlight      draw the cell in the cursor colour
//   oDraw_Periods        period count to render (wave jobs only, else 0)
//   iDraw_Ack            one-cycle completion pulse from the draw engine
//   oBusy                a job is pending or in flight
//   oTimeout_Err         sticky ack-timeout flag, cleared only by rst

module ui_redraw_scheduler #(
    parameter int unsigned NUM_CELLS   = 11,
    parameter int unsigned ACK_TIMEOUT = 4096,
    parameter int unsigned WAVE_REGION = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] iCursor_Index,
    input  logic [2:0] iActive_Periods_Num,
    output logic       oDraw_Req,
    output logic [3:0] oDraw_Region,
    output logic       oDraw_Highlight,
    output logic [2:0] oDraw_Periods,
    input  logic       iDraw_Ack,
    output logic       oBusy,
    output logic       oTimeout_Err
);

    localparam int unsigned CntW = $clog2(ACK_TIMEOUT) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(ACK_TIMEOUT - 1);
    localparam logic [3:0] WaveRegion = 4'(WAVE_REGION);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e                 state_q, state_d;
    logic [NUM_CELLS-1:0]   cell_pend_q, cell_pend_d;
    logic                   wave_pend_q, wave_pend_d;
    logic [3:0]             prev_cursor_q, prev_cursor_d;
    logic [2:0]             prev_periods_q, prev_periods_d;
    logic                   en_q;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   req_q, req_d;
    logic [3:0]             region_q, region_d;
    logic                   hl_q, hl_d;
    logic [2:0]             periods_q, periods_d;
    logic                   job_wave_q, job_wave_d;
    logic                   err_q, err_d;

    // Capture-side set masks, FSM-side clear and retry masks.
    logic [NUM_CELLS-1:0]   cell_set, cell_clr, cell_retry, pick_mask, retry_mask;
    logic                   wave_set, wave_clr, wave_retry;
    logic                   cell_found;
    logic [3:0]             pick_idx;

    // ------------------------------------------------------------------
    // Change capture: mark stale cells / waveform.
    // ------------------------------------------------------------------
    always_comb begin
        cell_set = '0;
        wave_set = 1'b0;
        if (en) begin
            if (!en_q) begin
                // Entering the menu screen: everything is stale.
                cell_set = '1;
                wave_set = 1'b1;
            end else begin
                if (iCursor_Index != prev_cursor_q) begin
                    // Old and new cursor cells both change colour; out-of-range
                    // indices simply match no bit.
                    for (int i = 0; i < NUM_CELLS; i++) begin
                        if (prev_cursor_q == 4'(i) || iCursor_Index == 4'(i)) begin
                            cell_set[i] = 1'b1;
                        end
                    end
                end
                if (iActive_Periods_Num != prev_periods_q) begin
                    wave_set = 1'b1;
                end
            end
        end
    end

    // prev_* track inputs only while enabled; the rising edge of en reloads them.
    always_comb begin
        prev_cursor_d  = en ? iCursor_Index       : prev_cursor_q;
        prev_periods_d = en ? iActive_Periods_Num : prev_periods_q;
    end

    // ------------------------------------------------------------------
    // Job selection: lowest set cell bit wins, wave only when no cell is pending.
    // ------------------------------------------------------------------
    always_comb begin
        pick_mask  = '0;
        pick_idx   = 4'd0;
        cell_found = 1'b0;
        for (int i = NUM_CELLS - 1; i >= 0; i--) begin
            if (cell_pend_q[i]) begin
                pick_mask    = '0;
                pick_mask[i] = 1'b1;
                pick_idx     = 4'(i);
                cell_found   = 1'b1;
            end
        end
    end

    // One-hot of the cell currently in flight, used to re-arm it on timeout.
    always_comb begin
        retry_mask = '0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (region_q == 4'(i)) begin
                retry_mask[i] = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Handshake FSM.
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        region_d   = region_q;
        hl_d       = hl_q;
        periods_d  = periods_q;
        job_wave_d = job_wave_q;
        err_d      = err_q;
        cell_clr   = '0;
        wave_clr   = 1'b0;
        cell_retry = '0;
        wave_retry = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (en && (cell_found || wave_pend_q)) begin
                    state_d = StWait;
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    if (cell_found) begin
                        region_d   = pick_idx;
                        hl_d       = (pick_idx == iCursor_Index);
                        periods_d  = 3'd0;
                        job_wave_d = 1'b0;
                        cell_clr   = pick_mask;
                    end else begin
                        region_d   = WaveRegion;
                        hl_d       = 1'b0;
                        periods_d  = iActive_Periods_Num;
                        job_wave_d = 1'b1;
                        wave_clr   = 1'b1;
                    end
                end
            end

            StWait: begin
                if (iDraw_Ack || cnt_q == CntLast) begin
                    state_d    = StIdle;
                    cnt_d      = '0;
                    req_d      = 1'b0;
                    region_d   = 4'd0;
                    hl_d       = 1'b0;
                    periods_d  = 3'd0;
                    job_wave_d = 1'b0;
                    if (!iDraw_Ack) begin
                        // Timed out: flag it and put the job back in the bitmap.
                        err_d = 1'b1;
                        if (job_wave_q) begin
                            wave_retry = 1'b1;
                        end else begin
                            cell_retry = retry_mask;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    // Pending bitmap: set wins over clear; en=0 wipes everything, retries included.
    always_comb begin
        if (en) begin
            cell_pend_d = (cell_pend_q & ~cell_clr) | cell_set | cell_retry;
            wave_pend_d = (wave_pend_q & ~wave_clr) | wave_set | wave_retry;
        end else begin
            cell_pend_d = '0;
            wave_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            cell_pend_q    <= '0;
            wave_pend_q    <= 1'b0;
            prev_cursor_q  <= 4'd0;
            prev_periods_q <= 3'd0;
            en_q           <= 1'b0;
            cnt_q          <= '0;
            req_q          <= 1'b0;
            region_q       <= 4'd0;
            hl_q           <= 1'b0;
            periods_q      <= 3'd0;
            job_wave_q     <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            cell_pend_q    <= cell_pend_d;
            wave_pend_q    <= wave_pend_d;
            prev_cursor_q  <= prev_cursor_d;
            prev_periods_q <= prev_periods_d;
            en_q           <= en;
            cnt_q          <= cnt_d;
            req_q          <= req_d;
            region_q       <= region_d;
            hl_q           <= hl_d;
            periods_q      <= periods_d;
            job_wave_q     <= job_wave_d;
            err_q          <= err_d;
        end
    end

    assign oDraw_Req       = req_q;
    assign oDraw_Region    = region_q;
    assign oDraw_Highlight = hl_q;
    assign oDraw_Periods   = periods_q;
    assign oTimeout_Err    = err_q;
    assign oBusy           = (state_q == StWait) | (|cell_pend_q) | wave_pend_q;

endmodule
